// File: rtl/dmem_lsu_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, FSM states and request record.
package rv32_mem_pkg;
    localparam int BE_W = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;
endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake bundle between the pipeline MEM stage and dmem_lsu.
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables / shifted data, load lane select and extension.
module dmem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rword,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata_sh,
    output logic [31:0]     rdata_ext,
    output logic            illegal,
    output logic            misalign
);
    logic [1:0]  lo_al;
    logic [31:0] rsh;

    always_comb begin
        illegal  = we ? (funct3 > F3_SW) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        misalign = 1'b0;
        lo_al    = addr_lo;
        // Halves and words are naturally aligned by dropping the offending low bits.
        case (funct3[1:0])
            2'b01: begin
                misalign = addr_lo[0];
                lo_al    = {addr_lo[1], 1'b0};
            end
            2'b10: begin
                misalign = (addr_lo != 2'b00);
                lo_al    = 2'b00;
            end
            default: ;
        endcase

        be = '0;
        if (we && !illegal) begin
            case (funct3[1:0])
                2'b00:   be = 4'b0001 << lo_al;
                2'b01:   be = 4'b0011 << lo_al;
                default: be = 4'b1111;
            endcase
        end
        wdata_sh = wdata << {lo_al, 3'b000};

        rsh = rword >> {lo_al, 3'b000};
        case (funct3)
            F3_LB:   rdata_ext = {{24{rsh[7]}}, rsh[7:0]};
            F3_LH:   rdata_ext = {{16{rsh[15]}}, rsh[15:0]};
            F3_LW:   rdata_ext = rword;
            F3_LBU:  rdata_ext = {24'd0, rsh[7:0]};
            F3_LHU:  rdata_ext = {16'd0, rsh[15:0]};
            default: rdata_ext = '0;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// RV32I data memory with LSU front end (MEM stage). Optional macro MISALIGN_TRAP_EN
// turns misaligned half/word accesses into errors instead of forcing alignment.
module dmem_lsu
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int READ_LAT = 1
) (
    input  logic      CLK,
    input  logic      rst_n,
    dmem_lsu_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] LAT_LAST = 2'((READ_LAT > 1) ? READ_LAT - 2 : 0);

    logic [BE_W-1:0][7:0] mem [DEPTH];

    lsu_req_t        req;
    lsu_state_e      state;
    logic [1:0]      lat_cnt;
    logic [31:0]     ld_data;
    logic            ld_err;
    logic [AW-1:0]   idx;
    logic [31:0]     rword;
    logic [BE_W-1:0] be;
    logic [31:0]     wdata_sh;
    logic [31:0]     rdata_ext;
    logic            illegal;
    logic            misalign;
    logic            err_c;
    logic            accept;
    logic            wr_en;

    assign req    = '{we: bus.req_we, funct3: bus.req_funct3, addr: bus.req_addr, wdata: bus.req_wdata};
    assign idx    = req.addr[AW+1:2];
    assign rword  = mem[idx];
    assign accept = bus.req_valid && bus.req_ready;

    wire unused_addr = ^{req.addr[31:AW+2]};

    dmem_lane_align u_align (
        .we        (req.we),
        .funct3    (req.funct3),
        .addr_lo   (req.addr[1:0]),
        .wdata     (req.wdata),
        .rword     (rword),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext),
        .illegal   (illegal),
        .misalign  (misalign)
    );

`ifdef MISALIGN_TRAP_EN
    assign err_c = illegal || misalign;
`else
    assign err_c = illegal;
    wire unused_misalign = misalign;
`endif

    assign wr_en = accept && req.we && !err_c;

    // RAM is deliberately not reset; a store lands on its accept edge.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < BE_W; i++)
            if (wr_en && be[i]) mem[idx][i] <= wdata_sh[8*i +: 8];
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            ld_data       <= '0;
            ld_err        <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    bus.req_ready <= 1'b0;
                    if (req.we || READ_LAT == 1) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= err_c;
                        bus.rsp_rdata <= (req.we || err_c) ? 32'd0 : rdata_ext;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= '0;
                        ld_data <= err_c ? 32'd0 : rdata_ext;
                        ld_err  <= err_c;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state         <= RESP;
                        lat_cnt       <= '0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= ld_data;
                        bus.rsp_err   <= ld_err;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one READ_LAT=1 and one READ_LAT=3 instance behind a shared driver.
module tb_dmem_lsu;
    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        rv = 1'b0;
    logic        we_t = 1'b0;
    logic [2:0]  f3_t = 3'd0;
    logic [31:0] addr_t = '0;
    logic [31:0] wd_t = '0;
    logic        rr = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    dmem_lsu_if if0 ();
    dmem_lsu_if if1 ();

    assign if0.req_valid  = rv && !sel;
    assign if1.req_valid  = rv && sel;
    assign if0.req_we     = we_t;
    assign if1.req_we     = we_t;
    assign if0.req_funct3 = f3_t;
    assign if1.req_funct3 = f3_t;
    assign if0.req_addr   = addr_t;
    assign if1.req_addr   = addr_t;
    assign if0.req_wdata  = wd_t;
    assign if1.req_wdata  = wd_t;
    assign if0.rsp_ready  = rr && !sel;
    assign if1.rsp_ready  = rr && sel;

    wire        vld_m = sel ? if1.rsp_valid : if0.rsp_valid;
    wire        rdy_m = sel ? if1.req_ready : if0.req_ready;
    wire [31:0] rd_m  = sel ? if1.rsp_rdata : if0.rsp_rdata;
    wire        err_m = sel ? if1.rsp_err   : if0.rsp_err;

    dmem_lsu #(.DEPTH(64), .READ_LAT(1)) u0 (.CLK(CLK), .rst_n(rst_n), .bus(if0));
    dmem_lsu #(.DEPTH(64), .READ_LAT(3)) u1 (.CLK(CLK), .rst_n(rst_n), .bus(if1));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", tag, act, exp);
        end
    endtask

    // Issue one access, check latency/data/err, hold rsp_ready low for `hold` extra cycles.
    task automatic access(input string tag, input logic s, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                          input int hold);
        int lat;
        sel = s;
        chk({tag, ".ready_pre"}, 32'(rdy_m), 32'd1);
        rv = 1'b1; we_t = w; f3_t = f3; addr_t = a; wd_t = wd;
        @(posedge CLK); #1;
        rv = 1'b0;
        lat = 1;
        while (!vld_m && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".rdata"}, rd_m, exp_rd);
        chk({tag, ".err"}, 32'(err_m), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            chk({tag, ".hold_vld"}, 32'(vld_m), 32'd1);
            chk({tag, ".hold_rdata"}, rd_m, exp_rd);
            chk({tag, ".hold_rdy"}, 32'(rdy_m), 32'd0);
        end
        rr = 1'b1;
        #2;
        chk({tag, ".rdy_hs"}, 32'(rdy_m), 32'd0);
        @(posedge CLK); #1;
        rr = 1'b0;
        chk({tag, ".rdy_post"}, 32'(rdy_m), 32'd1);
        chk({tag, ".vld_post"}, 32'(vld_m), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1 rst_n = 1'b1;
        chk("rst.ready", 32'(if0.req_ready), 32'd1);
        chk("rst.valid", 32'(if0.rsp_valid), 32'd0);
        chk("rst.rdata", if0.rsp_rdata, 32'd0);
        chk("rst.err", 32'(if0.rsp_err), 32'd0);
        chk("rst.valid1", 32'(if1.rsp_valid), 32'd0);

        // READ_LAT=1 instance
        access("sw10", 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, 0);
        access("lw10", 0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, 0);
        access("sw10z", 0, 1, 3'b010, 32'h10, 32'h0, 32'h0, 0, 1, 0);
        access("sb13", 0, 1, 3'b000, 32'h13, 32'h80, 32'h0, 0, 1, 0);
        access("lb13", 0, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0, 1, 0);
        access("lbu13", 0, 0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0, 1, 0);
        access("lw10b", 0, 0, 3'b010, 32'h10, 32'h0, 32'h80000000, 0, 1, 0);
        access("sw14", 0, 1, 3'b010, 32'h14, 32'h11223344, 32'h0, 0, 1, 0);
        access("sh16", 0, 1, 3'b001, 32'h16, 32'h1234ABCD, 32'h0, 0, 1, 0);
        access("lw14", 0, 0, 3'b010, 32'h14, 32'h0, 32'hABCD3344, 0, 1, 0);
        access("lh16", 0, 0, 3'b001, 32'h16, 32'h0, 32'hFFFFABCD, 0, 1, 0);
        access("lhu16", 0, 0, 3'b101, 32'h16, 32'h0, 32'h0000ABCD, 0, 1, 0);
        access("lb15", 0, 0, 3'b000, 32'h15, 32'h0, 32'h00000033, 0, 1, 0);
        access("sw100", 0, 1, 3'b010, 32'h100, 32'h1234, 32'h0, 0, 1, 0);
        access("lw000", 0, 0, 3'b010, 32'h0, 32'h0, 32'h1234, 0, 1, 0);
        access("ld011", 0, 0, 3'b011, 32'h0, 32'h0, 32'h0, 1, 1, 0);
        access("st101", 0, 1, 3'b101, 32'h0, 32'hFFFFFFFF, 32'h0, 1, 1, 0);
        access("lw000b", 0, 0, 3'b010, 32'h0, 32'h0, 32'h1234, 0, 1, 0);
`ifdef MISALIGN_TRAP_EN
        access("lw12", 0, 0, 3'b010, 32'h12, 32'h0, 32'h0, 1, 1, 0);
        access("sh11", 0, 1, 3'b001, 32'h11, 32'h5555, 32'h0, 1, 1, 0);
        access("lw10c", 0, 0, 3'b010, 32'h10, 32'h0, 32'h80000000, 0, 1, 0);
`else
        access("lw12", 0, 0, 3'b010, 32'h12, 32'h0, 32'h80000000, 0, 1, 0);
        access("sh11", 0, 1, 3'b001, 32'h11, 32'h5555, 32'h0, 0, 1, 0);
        access("lw10c", 0, 0, 3'b010, 32'h10, 32'h0, 32'h80005555, 0, 1, 0);
`endif

        // READ_LAT=3 instance
        access("l3.sw20", 1, 1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 0, 1, 0);
        access("l3.lw20", 1, 0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0, 3, 5);
        access("l3.ld111", 1, 0, 3'b111, 32'h20, 32'h0, 32'h0, 1, 3, 0);
        access("l3.lhu22", 1, 0, 3'b101, 32'h22, 32'h0, 32'h0000CAFE, 0, 3, 0);

        // Reset while a load sits in WAIT
        sel = 1'b1;
        rv = 1'b1; we_t = 1'b0; f3_t = 3'b010; addr_t = 32'h20;
        @(posedge CLK); #1;
        rv = 1'b0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            chk("rstw.valid", 32'(vld_m), 32'd0);
            chk("rstw.ready", 32'(rdy_m), 32'd1);
        end
        access("rstw.lw20", 1, 0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
